// File: rtl/bootram_ctrl.sv
// Boot RAM controller: presents four 2K x 8 byte-lane macros as one word memory on the
// PicoRV32 native bus, with a byte-stream loader that fills it before the CPU runs.
module bootram_ctrl #(
   parameter int ADDR_WIDTH = 11,
   parameter int LOAD_BYTES = 8192
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [31:0]           mem_addr,
   input  logic [31:0]           mem_wdata,
   input  logic [3:0]            mem_wstrb,
   output logic [31:0]           mem_rdata,
   input  logic                  ld_start,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [7:0]            ld_data,
   output logic                  ld_busy,
   output logic                  ld_done,
   output logic [3:0]            ram_ce,
   output logic                  ram_wre,
   output logic                  ram_oce,
   output logic [ADDR_WIDTH-1:0] ram_ad,
   output logic [31:0]           ram_din,
   input  logic [31:0]           ram_dout
);

   localparam int CW = ADDR_WIDTH + 2;
   localparam logic [CW-1:0] LAST_BYTE = CW'(LOAD_BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RESP    = 2'd2,
      ST_LOAD    = 2'd3
   } state_t;

   state_t                  state_r;
   logic [CW-1:0]           cnt_r;
   logic                    mem_ready_r;
   logic [31:0]             mem_rdata_r;
   logic                    ld_busy_r;
   logic                    ld_done_r;
   logic [ADDR_WIDTH-1:0]   cpu_word_s;
   logic                    ld_take_s;
   logic [3:0]              ram_ce_s;
   logic                    ram_wre_s;
   logic [ADDR_WIDTH-1:0]   ram_ad_s;
   logic [31:0]             ram_din_s;
   logic                    unused_addr_s;

   // Upper address bits alias; byte offset is replaced by the strobes.
   assign cpu_word_s    = mem_addr[ADDR_WIDTH+1:2];
   assign unused_addr_s = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};
   assign ld_take_s     = (state_r == ST_LOAD) && !ld_start && ld_valid;

   // RAM strobes decoded from the current state; held off entirely while in reset.
   always_comb begin
      ram_ce_s  = 4'h0;
      ram_wre_s = 1'b0;
      ram_ad_s  = '0;
      ram_din_s = 32'h0;
      if (resetn) begin
         case (state_r)
            ST_IDLE: begin
               if (!ld_start && mem_valid) begin
                  ram_ad_s = cpu_word_s;
                  if (mem_wstrb == 4'h0) begin
                     ram_ce_s = 4'hF;
                  end else begin
                     ram_ce_s  = mem_wstrb;
                     ram_wre_s = 1'b1;
                     ram_din_s = mem_wdata;
                  end
               end else begin
                  ram_ce_s = 4'h0;
               end
            end
            ST_LOAD: begin
               if (ld_take_s) begin
                  ram_ad_s  = cnt_r[CW-1:2];
                  ram_ce_s  = 4'b0001 << cnt_r[1:0];
                  ram_wre_s = 1'b1;
                  ram_din_s = {4{ld_data}};
               end else begin
                  ram_ce_s = 4'h0;
               end
            end
            default: ram_ce_s = 4'h0;
         endcase
      end else begin
         ram_ce_s = 4'h0;
      end
   end

   // Access/load sequencer with registered bus-side outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         mem_ready_r <= 1'b0;
         mem_rdata_r <= 32'h0;
         ld_busy_r   <= 1'b0;
         ld_done_r   <= 1'b0;
      end else begin
         mem_ready_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (ld_start) begin
                  state_r   <= ST_LOAD;
                  cnt_r     <= '0;
                  ld_done_r <= 1'b0;
                  ld_busy_r <= 1'b1;
               end else if (mem_valid) begin
                  if (mem_wstrb == 4'h0) begin
                     state_r <= ST_RD_WAIT;
                  end else begin
                     state_r     <= ST_RESP;
                     mem_ready_r <= 1'b1;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RD_WAIT: begin
               mem_rdata_r <= ram_dout;
               mem_ready_r <= 1'b1;
               state_r     <= ST_RESP;
            end
            ST_RESP: state_r <= ST_IDLE;
            ST_LOAD: begin
               if (ld_start) begin
                  cnt_r <= '0;
               end else if (ld_valid) begin
                  cnt_r <= cnt_r + CW'(1);
                  if (cnt_r == LAST_BYTE) begin
                     state_r   <= ST_IDLE;
                     ld_busy_r <= 1'b0;
                     ld_done_r <= 1'b1;
                  end else begin
                     state_r <= ST_LOAD;
                  end
               end else begin
                  state_r <= ST_LOAD;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               ld_busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign mem_ready = mem_ready_r;
   assign mem_rdata = mem_rdata_r;
   assign ld_busy   = ld_busy_r;
   assign ld_ready  = ld_busy_r;
   assign ld_done   = ld_done_r;
   assign ram_ce    = ram_ce_s;
   assign ram_wre   = ram_wre_s;
   assign ram_oce   = 1'b1;
   assign ram_ad    = ram_ad_s;
   assign ram_din   = ram_din_s;

endmodule

// File: tb/tb_bootram_ctrl.sv
// Bench for bootram_ctrl: byte-lane RAM stand-in, transaction-level model checked every
// cycle, and directed CPU/loader scenarios with literal expectations.
module tb_bootram_ctrl;

   localparam int AW = 11;
   localparam int LB = 8;

   logic          clk;
   logic          resetn;
   logic          mem_valid;
   logic          mem_ready;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_wstrb;
   logic [31:0]   mem_rdata;
   logic          ld_start;
   logic          ld_valid;
   logic          ld_ready;
   logic [7:0]    ld_data;
   logic          ld_busy;
   logic          ld_done;
   logic [3:0]    ram_ce;
   logic          ram_wre;
   logic          ram_oce;
   logic [AW-1:0] ram_ad;
   logic [31:0]   ram_din;
   logic [31:0]   ram_dout;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   bootram_ctrl #(.ADDR_WIDTH(AW), .LOAD_BYTES(LB)) dut (
      .clk(clk), .resetn(resetn),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
      .ld_busy(ld_busy), .ld_done(ld_done),
      .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_oce(ram_oce), .ram_ad(ram_ad),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Four byte-lane RAM macros with a registered read port.
   logic [31:0] bram [0:(1<<AW)-1];
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ram_ce[i]) begin
            if (ram_wre) bram[ram_ad][8*i +: 8] <= ram_din[8*i +: 8];
            else         ram_dout[8*i +: 8]     <= bram[ram_ad][8*i +: 8];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Transaction-level model: memory image, load progress and the cycle a response is due.
   logic [31:0] mdl_mem [0:(1<<AW)-1];
   logic [31:0] mdl_rdata = 32'h0;
   bit          mdl_loading = 1'b0;
   bit          mdl_done = 1'b0;
   int          mdl_cnt = 0;
   int          ready_at = -100;

   initial begin
      int sample;
      int w;
      forever begin
         @(posedge clk);
         sample = cyc;
         cyc++;
         if (!resetn) begin
            mdl_loading = 1'b0;
            mdl_done    = 1'b0;
            mdl_cnt     = 0;
            ready_at    = -100;
         end else if (mdl_loading) begin
            if (ld_start) mdl_cnt = 0;
            else if (ld_valid) begin
               mdl_mem[mdl_cnt / 4][8*(mdl_cnt % 4) +: 8] = ld_data;
               if (mdl_cnt == LB - 1) begin
                  mdl_loading = 1'b0;
                  mdl_done    = 1'b1;
               end
               mdl_cnt++;
            end
         end else if (sample > ready_at) begin
            if (ld_start) begin
               mdl_loading = 1'b1;
               mdl_cnt     = 0;
               mdl_done    = 1'b0;
            end else if (mem_valid) begin
               w = int'(mem_addr[AW+1:2]);
               if (mem_wstrb == 4'h0) begin
                  mdl_rdata = mdl_mem[w];
                  ready_at  = sample + 2;
               end else begin
                  for (int b = 0; b < 4; b++)
                     if (mem_wstrb[b]) mdl_mem[w][8*b +: 8] = mem_wdata[8*b +: 8];
                  ready_at = sample + 1;
               end
            end
         end
      end
   end

   // Every-cycle comparison of the bus/loader outputs against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("ram_oce", 32'(ram_oce), 32'd1);
         if (!resetn) begin
            chk("rst_ready", 32'(mem_ready), 32'd0);
            chk("rst_rdata", mem_rdata, 32'h0);
            chk("rst_busy", 32'(ld_busy), 32'd0);
            chk("rst_done", 32'(ld_done), 32'd0);
            chk("rst_ce", 32'(ram_ce), 32'd0);
         end else begin
            chk("mem_ready", 32'(mem_ready), 32'(ready_at == cyc));
            if (ready_at == cyc) chk("mem_rdata", mem_rdata, mdl_rdata);
            chk("ld_busy", 32'(ld_busy), 32'(mdl_loading));
            chk("ld_ready", 32'(ld_ready), 32'(mdl_loading));
            chk("ld_done", 32'(ld_done), 32'(mdl_done));
         end
      end
   end

   logic [AW-1:0] snap_ad;
   logic [3:0]    snap_ce;
   logic          snap_wre;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                             output logic [31:0] rd, output int lat);
      int st;
      mem_addr  = a;
      mem_wdata = wd;
      mem_wstrb = ws;
      mem_valid = 1'b1;
      st  = cyc;
      lat = -1;
      rd  = 32'h0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i == 0) begin
            snap_ad  = ram_ad;
            snap_ce  = ram_ce;
            snap_wre = ram_wre;
         end
         if (mem_ready) begin
            lat = cyc - st;
            rd  = mem_rdata;
            break;
         end
      end
      step();
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
   endtask

   task automatic start_load;
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
   endtask

   task automatic feed(input logic [7:0] first, input int n, input bit gap);
      for (int k = 0; k < n; k++) begin
         if (gap) begin
            ld_valid = 1'b0;
            step();
         end
         ld_valid = 1'b1;
         ld_data  = first + 8'(k);
         step();
      end
      ld_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int lat;
      resetn = 1'b0; mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
      mem_wstrb = 4'h0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h0;

      // Reset state
      @(negedge clk);
      chk("reset_ready", 32'(mem_ready), 32'd0);
      chk("reset_ldready", 32'(ld_ready), 32'd0);
      chk("reset_wre", 32'(ram_wre), 32'd0);
      chk("reset_ad", 32'(ram_ad), 32'd0);
      chk("reset_din", ram_din, 32'h0);
      step();
      resetn = 1'b1;
      step();

      // Loader byte outside LOAD is ignored
      ld_valid = 1'b1; ld_data = 8'h5A;
      @(negedge clk);
      chk("idle_ld_ready", 32'(ld_ready), 32'd0);
      chk("idle_ld_ce", 32'(ram_ce), 32'd0);
      step();
      ld_valid = 1'b0;

      // Full-word write then read back
      cpu_access(32'h10, 32'hDEADBEEF, 4'hF, rd, lat);
      chk("wr_ad", 32'(snap_ad), 32'd4);
      chk("wr_ce", 32'(snap_ce), 32'hF);
      chk("wr_wre", 32'(snap_wre), 32'd1);
      chk("wr_lat", 32'(lat), 32'd1);
      cpu_access(32'h10, 32'h0, 4'h0, rd, lat);
      chk("rd_lat", 32'(lat), 32'd2);
      chk("rd_data", rd, 32'hDEADBEEF);
      chk("rd_ce", 32'(snap_ce), 32'hF);
      chk("rd_wre", 32'(snap_wre), 32'd0);

      // Single-byte write merges into the word
      cpu_access(32'h10, 32'h00AA0000, 4'b0100, rd, lat);
      chk("bw_ce", 32'(snap_ce), 32'h4);
      cpu_access(32'h10, 32'h0, 4'h0, rd, lat);
      chk("bw_data", rd, 32'hDEAABEEF);
      cpu_access(32'h2010, 32'h0, 4'h0, rd, lat);
      chk("alias_data", rd, 32'hDEAABEEF);

      // Gapped load of 8 bytes
      start_load();
      feed(8'h01, LB, 1'b1);
      @(negedge clk);
      chk("load_busy_end", 32'(ld_busy), 32'd0);
      chk("load_done_end", 32'(ld_done), 32'd1);
      step();
      cpu_access(32'h0, 32'h0, 4'h0, rd, lat);
      chk("load_w0", rd, 32'h04030201);
      cpu_access(32'h4, 32'h0, 4'h0, rd, lat);
      chk("load_w1", rd, 32'h08070605);

      // Read raised together with ld_start waits for the load
      ld_start = 1'b1;
      fork
         cpu_access(32'h4, 32'h0, 4'h0, rd, lat);
         begin
            step();
            ld_start = 1'b0;
            feed(8'h11, LB, 1'b0);
         end
      join
      chk("stall_lat", 32'(lat), 32'd11);
      chk("stall_data", rd, 32'h18171615);
      chk("stall_done", 32'(ld_done), 32'd1);

      // Reset after three loaded bytes
      start_load();
      feed(8'hA1, 3, 1'b0);
      ld_valid = 1'b1; ld_data = 8'hA4; resetn = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 32'(ld_busy), 32'd0);
      chk("midrst_done", 32'(ld_done), 32'd0);
      chk("midrst_ce", 32'(ram_ce), 32'd0);
      step();
      ld_valid = 1'b0;
      step();
      resetn = 1'b1;
      step();
      cpu_access(32'h0, 32'h0, 4'h0, rd, lat);
      chk("midrst_lat", 32'(lat), 32'd2);
      chk("midrst_w0", rd, 32'h14A3A2A1);
      chk("midrst_done_after", 32'(ld_done), 32'd0);

      step();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
